muldiv_unit: RTL and testbench

- Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers for the multi-cycle MIPS core.
- Replaces the fixed separate DIV/MULT blocks and the DivCtrl/MultCtrl muxes that feed HI/LO.
- Supports signed and unsigned multiply and divide at width WIDTH, plus direct HI/LO writes (MTHI/MTLO).
- Reports divide-by-zero with a one-cycle flag for the exception logic.

---
 rtl/muldiv_pkg.sv | 26 ++
 rtl/muldiv_step.sv | 41 ++++
 rtl/muldiv_unit.sv | 118 +++++++++++
 tb/tb_muldiv_unit.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the multi-cycle multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PREP = 2'b01,
        RUN  = 2'b10,
        FIX  = 2'b11
    } state_e;

    function automatic logic op_is_div(input op_e o);
        return (o == OP_DIV) || (o == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input op_e o);
        return (o == OP_MULT) || (o == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             div,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic           ge;

    always_comb begin
        sum      = {1'b0, acc} + {1'b0, b};
        shifted  = {acc, q[WIDTH-1]};
        ge       = shifted >= {1'b0, b};
        acc_next = acc;
        q_next   = q;
        if (div) begin
            // The true difference is below b, so a WIDTH-bit subtract is exact.
            if (ge) begin
                acc_next = shifted[WIDTH-1:0] - b;
                q_next   = {q[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = shifted[WIDTH-1:0];
                q_next   = {q[WIDTH-2:0], 1'b0};
            end
        end else if (q[0]) begin
            acc_next = sum[WIDTH:1];
            q_next   = {sum[0], q[WIDTH-1:1]};
        end else begin
            acc_next = {1'b0, acc[WIDTH-1:1]};
            q_next   = {acc[0], q[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle signed/unsigned multiply/divide with architectural HI/LO.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_e             state;
    op_e                op_r;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   q;
    logic [WIDTH-1:0]   b_r;
    logic               neg_q;
    logic               neg_r;
    logic               dz;
    logic [WIDTH-1:0]   acc_next;
    logic [WIDTH-1:0]   q_next;
    logic [2*WIDTH-1:0] prod;
    logic               sgn;
    logic               is_div;

    assign busy   = (state != IDLE);
    assign sgn    = op_is_signed(op_r);
    assign is_div = op_is_div(op_r);
    assign prod   = neg_q ? -{acc, q} : {acc, q};

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .div      (is_div),
        .acc      (acc),
        .q        (q),
        .b        (b_r),
        .acc_next (acc_next),
        .q_next   (q_next)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            op_r     <= OP_MULT;
            cnt      <= '0;
            acc      <= '0;
            q        <= '0;
            b_r      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            dz       <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        op_r  <= op_e'(op);
                        q     <= a;
                        b_r   <= b;
                        state <= PREP;
                    end else begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                    end
                end
                PREP: begin
                    neg_q <= sgn & (q[WIDTH-1] ^ b_r[WIDTH-1]);
                    neg_r <= sgn & q[WIDTH-1];
                    q     <= (sgn && q[WIDTH-1]) ? -q : q;
                    b_r   <= (sgn && b_r[WIDTH-1]) ? -b_r : b_r;
                    acc   <= '0;
                    cnt   <= '0;
                    dz    <= is_div && (b_r == '0);
                    state <= (is_div && (b_r == '0)) ? FIX : RUN;
                end
                RUN: begin
                    acc <= acc_next;
                    q   <= q_next;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) state <= FIX;
                end
                FIX: begin
                    // Remainder follows the dividend sign; quotient follows sign xor.
                    if (!dz) begin
                        if (is_div) begin
                            lo <= neg_q ? -q : q;
                            hi <= neg_r ? -acc : acc;
                        end else begin
                            {hi, lo} <= prod;
                        end
                    end
                    done     <= 1'b1;
                    div_zero <= dz;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit at WIDTH=32.
module tb_muldiv_unit;

    logic        clock;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .hi_we    (hi_we),
        .lo_we    (lo_we),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) if (done) done_cnt++;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic start_op(input logic [1:0] o, input logic [31:0] x,
                            input logic [31:0] y);
        @(negedge clock);
        op = o;
        a = x;
        b = y;
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output int n, output logic all_busy);
        n = 0;
        all_busy = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (!busy) all_busy = 1'b0;
            @(posedge clock);
            #1 n++;
            if (done) break;
        end
    endtask

    task automatic run(input string tag, input logic [1:0] o,
                       input logic [31:0] x, input logic [31:0] y,
                       input int lat, input logic [31:0] ehi,
                       input logic [31:0] elo, input logic edz);
        int n;
        logic ab;
        start_op(o, x, y);
        wait_done(n, ab);
        check({tag, "_lat"}, 32'(n), 32'(lat));
        check({tag, "_busy"}, 32'(ab), 32'd1);
        check({tag, "_done_busy"}, 32'(busy), 32'd0);
        check({tag, "_dz"}, 32'(div_zero), 32'(edz));
        check({tag, "_hi"}, hi, ehi);
        check({tag, "_lo"}, lo, elo);
    endtask

    initial begin
        int n;
        int d0;
        logic ab;
        reset = 1'b0;
        start = 1'b0;
        op = 2'b00;
        a = '0;
        b = '0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        wdata = '0;
        #12;
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_dz", 32'(div_zero), 32'd0);
        @(negedge clock);
        reset = 1'b1;

        run("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 34,
            32'hFFFFFFFE, 32'h00000001, 1'b0);
        run("mult_neg", 2'b00, 32'hFFFFFFFD, 32'd7, 34,
            32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
        run("divu_b2b", 2'b11, 32'd100, 32'd7, 34, 32'd2, 32'd14, 1'b0);
        run("div_neg", 2'b10, 32'hFFFFFFF9, 32'd2, 34,
            32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        run("div_min", 2'b10, 32'h80000000, 32'hFFFFFFFF, 34,
            32'h0, 32'h80000000, 1'b0);
        run("div_negb", 2'b10, 32'd7, 32'hFFFFFFFE, 34,
            32'd1, 32'hFFFFFFFD, 1'b0);
        run("multu_sh", 2'b01, 32'h00010000, 32'h00010000, 34,
            32'd1, 32'd0, 1'b0);

        @(negedge clock);
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'hAAAA;
        @(negedge clock);
        hi_we = 1'b0;
        lo_we = 1'b0;
        check("mt_both_hi", hi, 32'hAAAA);
        check("mt_both_lo", lo, 32'hAAAA);
        hi_we = 1'b1;
        wdata = 32'h1234;
        @(negedge clock);
        hi_we = 1'b0;
        lo_we = 1'b1;
        wdata = 32'h5678;
        @(negedge clock);
        lo_we = 1'b0;
        check("mthi", hi, 32'h1234);
        check("mtlo", lo, 32'h5678);
        run("div_zero", 2'b10, 32'd9, 32'd0, 2, 32'h1234, 32'h5678, 1'b1);
        @(posedge clock);
        #1;
        check("dz_pulse_end", 32'(div_zero), 32'd0);
        check("done_pulse_end", 32'(done), 32'd0);

        d0 = done_cnt;
        start_op(2'b01, 32'h12345678, 32'h10);
        repeat (10) @(posedge clock);
        @(negedge clock);
        start = 1'b1;
        op = 2'b11;
        a = 32'd1;
        b = 32'd1;
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'hFFFF;
        @(posedge clock);
        #1;
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        wait_done(n, ab);
        check("mid_busy", 32'(ab), 32'd1);
        check("mid_hi", hi, 32'd1);
        check("mid_lo", lo, 32'h23456780);
        repeat (40) @(posedge clock);
        #1;
        check("mid_done_cnt", 32'(done_cnt - d0), 32'd1);

        d0 = done_cnt;
        start_op(2'b01, 32'hFFFFFFFF, 32'h3);
        repeat (5) @(posedge clock);
        #2 reset = 1'b0;
        #1;
        check("arst_hi", hi, 32'h0);
        check("arst_lo", lo, 32'h0);
        check("arst_busy", 32'(busy), 32'd0);
        repeat (40) @(posedge clock);
        #1;
        check("arst_no_done", 32'(done_cnt - d0), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        run("post_rst", 2'b10, 32'd100, 32'hFFFFFFF9, 34,
            32'd2, 32'hFFFFFFF2, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
